// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file port controller.
package rf_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Decode read port, writeback port and register-file port of regfile_port_ctrl.
interface regfile_port_ctrl_if import rf_ctrl_pkg::*; ();

    logic                  rd_req_valid;
    logic [REG_ADDR_W-1:0] rd_req_rs1;
    logic [REG_ADDR_W-1:0] rd_req_rs2;
    logic                  rd_req_ready;
    logic                  rd_resp_valid;
    logic [XLEN-1:0]       rd_resp_data1;
    logic [XLEN-1:0]       rd_resp_data2;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_ready;
    logic                  rf_write;
    logic [XLEN-1:0]       rf_write_data;
    logic [REG_ADDR_W-1:0] rf_rs1;
    logic [REG_ADDR_W-1:0] rf_rs2;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_out1;
    logic [XLEN-1:0]       rf_out2;
    logic                  init_done;

    // Controller side
    modport master (
        input  rd_req_valid, rd_req_rs1, rd_req_rs2, wb_valid, wb_rd, wb_data, rf_out1, rf_out2,
        output rd_req_ready, rd_resp_valid, rd_resp_data1, rd_resp_data2, wb_ready,
        output rf_write, rf_write_data, rf_rs1, rf_rs2, rf_rd, init_done
    );

    // Decode / writeback / register-file side
    modport slave (
        output rd_req_valid, rd_req_rs1, rd_req_rs2, wb_valid, wb_rd, wb_data, rf_out1, rf_out2,
        input  rd_req_ready, rd_resp_valid, rd_resp_data1, rd_resp_data2, wb_ready,
        input  rf_write, rf_write_data, rf_rs1, rf_rs2, rf_rd, init_done
    );

endinterface

// File: rtl/wb_fifo.sv
// Writeback FIFO with a combinational youngest-match lookup for two read addresses.
module wb_fifo import rf_ctrl_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             push_entry,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    input  logic [REG_ADDR_W-1:0] addr1,
    input  logic [REG_ADDR_W-1:0] addr2,
    output logic                  hit1,
    output logic                  hit2,
    output logic [XLEN-1:0]       data1,
    output logic [XLEN-1:0]       data2
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   count_s;
    logic [PTR_W-1:0] idx_s;

    // The extra pointer MSB separates full from empty when the indices coincide.
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign head    = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage; only slots between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= push_entry;
        end
    end

    // Oldest-to-youngest scan so the youngest match overwrites earlier ones
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        idx_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count_s)) begin
                idx_s = rd_ptr_r[PTR_W-1:0] + PTR_W'(k);
                if (mem_r[idx_s].rd == addr1) begin
                    hit1  = 1'b1;
                    data1 = mem_r[idx_s].data;
                end else begin
                    hit1  = hit1;
                end
                if (mem_r[idx_s].rd == addr2) begin
                    hit2  = 1'b1;
                    data2 = mem_r[idx_s].data;
                end else begin
                    hit2  = hit2;
                end
            end else begin
                idx_s = idx_s;
            end
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: zeroes the file after reset, then arbitrates reads against
// a queued writeback stream. Build macro RFCTRL_FWD_EN forwards queued data to reads.
module regfile_port_ctrl import rf_ctrl_pkg::*; #(
    parameter int WB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    regfile_port_ctrl_if.master bus
);
    state_e                state_r;
    state_e                state_s;
    logic [REG_ADDR_W-1:0] init_cnt_r;
    logic                  fifo_full_s, fifo_empty_s;
    logic                  hit1_s, hit2_s, fwd_hit1_s, fwd_hit2_s;
    logic [XLEN-1:0]       fwd1_s, fwd2_s;
    wb_entry_t             head_s, push_entry_s;
    logic                  push_s, pop_s, rd_ready_s, rd_fire_s, stall_s;
    logic                  resp_valid_r, resp_valid_s, zero1_r, zero2_r, hit1_r, hit2_r;
    logic [XLEN-1:0]       fwd1_r, fwd2_r, hold1_r, hold2_r, data1_s, data2_s;

    assign push_entry_s = '{rd: bus.wb_rd, data: bus.wb_data};

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk(clk), .rst(rst), .push(push_s), .pop(pop_s),
        .push_entry(push_entry_s), .head(head_s), .full(fifo_full_s), .empty(fifo_empty_s),
        .addr1(bus.rd_req_rs1), .addr2(bus.rd_req_rs2),
        .hit1(hit1_s), .hit2(hit2_s), .data1(fwd1_s), .data2(fwd2_s)
    );

    // Hazard policy: forward queued data, or hold the read until the match drains
    always_comb begin
`ifdef RFCTRL_FWD_EN
        stall_s    = 1'b0;
        fwd_hit1_s = hit1_s;
        fwd_hit2_s = hit2_s;
`else
        stall_s    = hit1_s || hit2_s;
        fwd_hit1_s = 1'b0;
        fwd_hit2_s = 1'b0;
`endif
    end

    // State register and clear counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= INIT;
            init_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == INIT) begin
                init_cnt_r <= init_cnt_r + 5'd1;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            INIT: begin
                if (init_cnt_r == 5'(NREG - 1)) begin
                    state_s = RUN;
                end else begin
                    state_s = INIT;
                end
            end
            RUN:     state_s = RUN;
            default: state_s = INIT;
        endcase
    end

    // One register-file operation per cycle: clear, read, drain or idle read
    always_comb begin
        bus.rd_req_ready  = 1'b0;
        bus.wb_ready      = 1'b0;
        bus.rf_write      = 1'b0;
        bus.rf_write_data = '0;
        bus.rf_rs1        = '0;
        bus.rf_rs2        = '0;
        bus.rf_rd         = '0;
        bus.init_done     = 1'b0;
        rd_ready_s        = 1'b0;
        rd_fire_s         = 1'b0;
        push_s            = 1'b0;
        pop_s             = 1'b0;
        if (rst) begin
            bus.rf_write = 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    bus.rf_write = 1'b1;
                    bus.rf_rd    = init_cnt_r;
                end
                RUN: begin
                    bus.init_done    = 1'b1;
                    rd_ready_s       = !fifo_full_s && !stall_s;
                    bus.rd_req_ready = rd_ready_s;
                    bus.wb_ready     = !fifo_full_s;
                    rd_fire_s        = bus.rd_req_valid && rd_ready_s;
                    push_s           = bus.wb_valid && !fifo_full_s && (bus.wb_rd != 5'd0);
                    pop_s            = !rd_fire_s && !fifo_empty_s;
                    bus.rf_rs1       = bus.rd_req_rs1;
                    bus.rf_rs2       = bus.rd_req_rs2;
                    if (pop_s) begin
                        bus.rf_write      = 1'b1;
                        bus.rf_rd         = head_s.rd;
                        bus.rf_write_data = head_s.data;
                    end else begin
                        bus.rf_write = 1'b0;
                    end
                end
                default: bus.rf_write = 1'b0;
            endcase
        end
    end

    // Snapshot zero/forward status at acceptance; queue contents pushed later are invisible
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            zero1_r      <= 1'b0;
            zero2_r      <= 1'b0;
            hit1_r       <= 1'b0;
            hit2_r       <= 1'b0;
            fwd1_r       <= '0;
            fwd2_r       <= '0;
            hold1_r      <= '0;
            hold2_r      <= '0;
        end else begin
            resp_valid_r <= rd_fire_s;
            hold1_r      <= data1_s;
            hold2_r      <= data2_s;
            if (rd_fire_s) begin
                zero1_r <= (bus.rd_req_rs1 == 5'd0);
                zero2_r <= (bus.rd_req_rs2 == 5'd0);
                hit1_r  <= fwd_hit1_s;
                hit2_r  <= fwd_hit2_s;
                fwd1_r  <= fwd1_s;
                fwd2_r  <= fwd2_s;
            end else begin
                zero1_r <= zero1_r;
                zero2_r <= zero2_r;
                hit1_r  <= hit1_r;
                hit2_r  <= hit2_r;
                fwd1_r  <= fwd1_r;
                fwd2_r  <= fwd2_r;
            end
        end
    end

    // Response mux; rf_out arrives one cycle after the read so it cannot be registered first
    always_comb begin
        resp_valid_s = resp_valid_r && !rst;
        if (resp_valid_s) begin
            data1_s = zero1_r ? '0 : (hit1_r ? fwd1_r : bus.rf_out1);
            data2_s = zero2_r ? '0 : (hit2_r ? fwd2_r : bus.rf_out2);
        end else begin
            data1_s = hold1_r;
            data2_s = hold2_r;
        end
    end

    assign bus.rd_resp_valid = resp_valid_s;
    assign bus.rd_resp_data1 = data1_s;
    assign bus.rd_resp_data2 = data2_s;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed plus randomized bench for regfile_port_ctrl against an architectural register model.
module tb_regfile_port_ctrl;
    import rf_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    regfile_port_ctrl_if bus ();
    regfile_port_ctrl #(.WB_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Register file: no reset, starts with nonzero garbage, registered read ports
    logic [XLEN-1:0] rf_mem [NREG];
    bit              seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= $urandom | 32'h1;
            seeded <= 1'b1;
        end else if (bus.rf_write) begin
            rf_mem[bus.rf_rd] <= bus.rf_write_data;
        end else begin
            bus.rf_out1 <= rf_mem[bus.rf_rs1];
            bus.rf_out2 <= rf_mem[bus.rf_rs2];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Architectural view: value of the latest accepted writeback per register
    logic [XLEN-1:0] arch [NREG];
    bit              pend = 1'b0;
    logic [XLEN-1:0] exp1, exp2, last1, last2;
    logic            s_valid, s_rdy, s_wbrdy, s_init, s_rfw, s_rd_fire = 1'b0, s_wb_fire = 1'b0;
    logic [4:0]      s_rfrd, s_rs1, s_rs2;
    logic [XLEN-1:0] s_rfwd, s_d1, s_d2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score responses, record handshakes in the model
    task automatic step();
        @(negedge clk);
        s_valid = bus.rd_resp_valid;  s_d1 = bus.rd_resp_data1;  s_d2 = bus.rd_resp_data2;
        s_rdy = bus.rd_req_ready;     s_wbrdy = bus.wb_ready;    s_init = bus.init_done;
        s_rfw = bus.rf_write;         s_rfrd = bus.rf_rd;        s_rfwd = bus.rf_write_data;
        s_rs1 = bus.rf_rs1;           s_rs2 = bus.rf_rs2;
        s_rd_fire = bus.rd_req_valid && bus.rd_req_ready;
        s_wb_fire = bus.wb_valid && bus.wb_ready;
        if (rst) begin
            check("resp_during_rst", s_valid, 1'b0);
            pend = 1'b0;
            last1 = '0;
            last2 = '0;
            for (int r = 0; r < NREG; r++) arch[r] = '0;
        end else begin
            check("resp_valid", s_valid, pend);
            if (pend) begin
                check("resp_data1", s_d1, exp1);
                check("resp_data2", s_d2, exp2);
                last1 = exp1;
                last2 = exp2;
            end else begin
                check("hold_data", {s_d1, s_d2}, {last1, last2});
            end
            pend = s_rd_fire;
            if (s_rd_fire) begin
                exp1 = arch[bus.rd_req_rs1];
                exp2 = arch[bus.rd_req_rs2];
            end
            if (s_wb_fire && bus.wb_rd != 5'd0) arch[bus.wb_rd] = bus.wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [31:0] data);
        int n = 0;
        bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
        do begin step(); n++; end while (!s_wb_fire && n < 40);
        check("wb_accept", s_wb_fire, 1'b1);
        bus.wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] rs1, input logic [4:0] rs2, output int waited);
        waited = 0;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = rs1; bus.rd_req_rs2 = rs2;
        step();
        while (!s_rd_fire && waited < 40) begin waited++; step(); end
        check("rd_accept", s_rd_fire, 1'b1);
        bus.rd_req_valid = 1'b0;
    endtask

    task automatic check_init();
        for (int i = 0; i < NREG; i++) begin
            step();
            check("init_cycle", {s_rfw, s_rfrd, s_rfwd, s_rdy, s_wbrdy, s_init},
                  {1'b1, 5'(i), 32'h0, 3'b000});
        end
        step();
        check("init_done", {s_init, s_wbrdy, s_rfw}, 3'b110);
        for (int r = 0; r < NREG; r++) check("cleared", rf_mem[r], 32'h0);
    endtask

    initial begin
        int w, q, p;
        logic [31:0] vals [5];
        bus.rd_req_valid = 1'b0; bus.rd_req_rs1 = '0; bus.rd_req_rs2 = '0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        check("rst_flags", {s_valid, s_rdy, s_wbrdy, s_init, s_rfw}, 5'b0);
        check("rst_data", {s_d1, s_d2}, 64'h0);
        check("rst_rf", {s_rfrd, s_rs1, s_rs2, s_rfwd}, 47'h0);
        rst = 1'b0;
        check_init();

        // Simple write then read through the register file
        do_wb(5'd5, 32'hDEAD_BEEF);
        repeat (2) step();
        do_read(5'd5, 5'd0, w);
        check("x5_no_wait", w, 0);
        step();
        check("x5_resp", {s_valid, s_d1, s_d2}, {1'b1, 32'hDEAD_BEEF, 32'h0});

        // Back-to-back writes to one register followed by a read of it
        do_wb(5'd7, 32'h11);
        do_wb(5'd7, 32'h22);
        do_read(5'd7, 5'd0, w);
`ifdef RFCTRL_FWD_EN
        check("x7_wait", w, 0);
`else
        check("x7_wait", w, 1);
`endif
        step();
        check("x7_resp", {s_valid, s_d1}, {1'b1, 32'h22});
        repeat (4) step();

        // Continuous reads while five writebacks arrive: queue fills and drains only when full
        for (int i = 0; i < 5; i++) vals[i] = $urandom;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd1; bus.rd_req_rs2 = 5'd2;
        q = 0; p = 0;
        for (int c = 0; c < 12; c++) begin
            bus.wb_valid = (p < 5); bus.wb_rd = 5'(10 + p); bus.wb_data = vals[p % 5];
            step();
            check("full_wb_ready", s_wbrdy, q < 4);
            check("full_rd_ready", s_rdy, q < 4);
            if (q == 4) q--;
            if (s_wb_fire) begin p++; q++; end
        end
        check("five_pushed", p, 5);
        bus.rd_req_valid = 1'b0; bus.wb_valid = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 5; i++) check("full_landed", rf_mem[10 + i], vals[i]);

        // x0 writeback is dropped and never reaches the register file
        do_wb(5'd0, 32'h1234);
        step();
        check("x0_no_drain", s_rfw, 1'b0);
        do_read(5'd0, 5'd0, w);
        step();
        check("x0_resp", {s_valid, s_d1}, {1'b1, 32'h0});

        // Reset with three queued writebacks and a response in flight
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd1; bus.rd_req_rs2 = 5'd2;
        for (int i = 0; i < 3; i++) do_wb(5'(20 + i), 32'hC0DE_0000 + 32'(i));
        bus.rd_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_init();
        repeat (3) begin
            step();
            check("post_rst_idle", s_rfw, 1'b0);
        end
        for (int i = 0; i < 3; i++) check("queued_discarded", rf_mem[20 + i], 32'h0);

        // Randomized traffic over a small address window to provoke hazards
        for (int c = 0; c < 400; c++) begin
            if (!bus.rd_req_valid || s_rd_fire) begin
                bus.rd_req_valid = 1'($urandom_range(0, 1));
                bus.rd_req_rs1 = 5'($urandom_range(0, 7));
                bus.rd_req_rs2 = 5'($urandom_range(0, 7));
            end
            if (!bus.wb_valid || s_wb_fire) begin
                bus.wb_valid = 1'($urandom_range(0, 1));
                bus.wb_rd = 5'($urandom_range(0, 7));
                bus.wb_data = $urandom;
            end
            step();
        end
        bus.rd_req_valid = 1'b0; bus.wb_valid = 1'b0;
        repeat (10) step();
        for (int r = 0; r < NREG; r++) check("final_rf", rf_mem[r], arch[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
Initiator-side controller for the 32x32 single-port register file (read rs1/rs2 when write=0, write rd when write=1, one operation per clock). Arbitrates decode-stage read requests against writeback-stage write requests and buffers writebacks in a small FIFO. Forwards pending writeback data to reads. After reset, clears all 32 registers, since the register file itself has no reset. Sits between decode/writeback and the register file in the core datapath.

Parameters:
XLEN, 32, data width; must match the register file.
NREG, 32, register count; fixed at 32 because addresses are 5 bits.
WB_DEPTH, 4, writeback FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock; rising-edge only.
rst  input  1  synchronous, active-high reset.
rd_req_valid  input  1  read request present.
rd_req_rs1  input  5  source address 1.
rd_req_rs2  input  5  source address 2.
rd_req_ready  output  1  read request accepted when valid && ready.
rd_resp_valid  output  1  response strobe, one cycle wide.
rd_resp_data1  output  XLEN  value of rs1.
rd_resp_data2  output  XLEN  value of rs2.
wb_valid  input  1  writeback request present.
wb_rd  input  5  destination address.
wb_data  input  XLEN  writeback data.
wb_ready  output  1  writeback accepted when valid && ready.
rf_write  output  1  to register file write input.
rf_write_data  output  XLEN  to register file write_data input.
rf_rs1  output  5  to register file rs1 input.
rf_rs2  output  5  to register file rs2 input.
rf_rd  output  5  to register file rd input.
rf_out1  input  XLEN  from register file out1; registered, 1-cycle latency.
rf_out2  input  XLEN  from register file out2; registered, 1-cycle latency.
init_done  output  1  high once register clearing is complete.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. Both are fixed.
- Reset values:
  - state=INIT, init counter=0, FIFO empty.
  - rd_resp_valid=0, rd_resp_data1/2=0.
  - rd_req_ready=0, wb_ready=0, init_done=0.
  - rf_write=0, all rf_* addresses and data=0.
- Asserting rst mid-operation discards queued writebacks and the in-flight response, then restarts INIT.
- INIT state:
  - rf_write=1, rf_rd=counter, rf_write_data=0.
  - Counter runs 0..31, so INIT lasts exactly 32 cycles.
  - On counter==31, go to RUN. init_done=1 from the first RUN cycle.
  - Both ready outputs stay 0 throughout INIT.
- RUN state: exactly one register file operation per cycle.
  - rd_req_ready = !fifo_full && !stall. stall is defined only when RFCTRL_FWD_EN is absent.
  - Read accepted in cycle N:
    - rf_write=0; rf_rs1/rf_rs2 driven combinationally from the request.
    - rd_resp_valid=1 in cycle N+1.
  - Otherwise, if the FIFO is non-empty: pop the oldest entry and drive rf_write=1 with its rd/data.
  - Otherwise: rf_write=0 (idle read, result ignored).
  - Reads win over drains unless the FIFO is full. When full, rd_req_ready=0, so the drain proceeds.
- Writebacks:
  - wb_ready = RUN && !fifo_full.
  - Push and pop in the same cycle are allowed.
  - wb_rd==0 is accepted but not enqueued (x0 writes dropped).
- Ordering:
  - A writeback accepted in the same cycle as a read is ordered after that read; the read never sees it.
  - FIFO contents at read acceptance are snapshotted into per-operand hit/data registers.
- Response data, per operand:
  - Address 0 returns 0.
  - Otherwise, a forward hit returns the youngest matching FIFO entry.
  - Otherwise, returns rf_out.
- rd_resp_data1/2 hold their last value when rd_resp_valid=0.
- FIFO pointers wrap modulo WB_DEPTH; full/empty are tracked with an extra pointer bit.

Optional Feature:
RFCTRL_FWD_EN.
- Defined: reads forward from matching FIFO entries (youngest wins); stall=0.
- Undefined: no forwarding.
  - stall=1 while any valid FIFO entry has nonzero rd equal to rd_req_rs1 or rd_req_rs2.
  - The FIFO drains until no entry matches; a response then always comes from rf_out or zero.

Decomposition:
- Package rf_ctrl_pkg: XLEN, NREG, REG_ADDR_W=5, state enum {INIT, RUN}, wb_entry_t {rd, data}.
- One sub-module, wb_fifo: circular buffer with push/pop, full/empty, and a combinational two-address youngest-match search port.

Test Plan:
- Reset, then hold: rf_write=1 for exactly 32 cycles with rf_rd 0..31 and data 0; init_done rises on cycle 33; both ready outputs are 0 before that.
- After init, wb x5=0xDEAD_BEEF, idle 2 cycles, read rs1=5 rs2=0 → rd_resp_valid one cycle later, data1=0xDEADBEEF, data2=0.
- wb x7=0x11 then x7=0x22 back-to-back, read rs1=7 in the next cycle:
  - Forwarding defined → data1=0x22 with no stall.
  - Forwarding undefined → rd_req_ready=0 until both drain, then data1=0x22.
- Hold rd_req_valid continuously while pushing 5 writebacks (WB_DEPTH=4) → wb_ready drops at 4 queued; reads stall only while full; all 5 values eventually land in the register file.
- wb x0=0x1234 then read rs1=0 → data1=0, and the FIFO stays empty.
- rst pulsed while 3 writebacks are queued → FIFO empties, no response issued, INIT repeats with 32 zero writes.
